// File: rtl/oflow_conflict_resolve_gen2.sv
// Conflict resolver: scans the score board, keeps the minimum-score holder per ID
// and marks every loser as fallback. Threshold abort is built only with OFLOW_CR_THRESHOLD_EN.
module oflow_conflict_resolve_gen2 #(
    parameter int NUM_ROWS         = 4,
    parameter int NUM_PES          = 4,
    parameter int ID_W             = 12,
    parameter int SCORE_W          = 16,
    parameter int HIST_DEPTH       = 16,
    parameter int MAX_CONFLICTS_TH = 10,
    localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
    localparam int PE_W  = (NUM_PES > 1) ? $clog2(NUM_PES) : 1,
    localparam int CNT_W = $clog2(HIST_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset_N,
    input  logic               start,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic               th_hit,
    output logic               overflow,
    output logic [CNT_W-1:0]   num_ids,
    output logic [ROW_W-1:0]   rd_row,
    output logic [PE_W-1:0]    rd_pe,
    input  logic [SCORE_W-1:0] rd_score,
    input  logic [ID_W-1:0]    rd_id,
    output logic               wr_en,
    output logic [ROW_W-1:0]   wr_row,
    output logic [PE_W-1:0]    wr_pe,
    output logic               wr_data
);

    // state   | meaning
    // IDLE    | waiting for start
    // READ    | score-board address driven, entry captured at the edge
    // RESOLVE | CAM lookup, slot update, loser write, pointer advance
    // DONE    | one-cycle done pulse
    typedef enum logic [1:0] {IDLE, READ, RESOLVE, DONE} state_t;

    localparam int               IDX_W    = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;
    localparam logic [CNT_W-1:0] CNT_SAT  = '1;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);
    localparam logic [PE_W-1:0]  LAST_PE  = PE_W'(NUM_PES - 1);

    if (MAX_CONFLICTS_TH < 2) begin : g_bad_threshold
        $error("MAX_CONFLICTS_TH must be at least 2");
    end

    state_t             state_q;
    logic [ROW_W-1:0]   ptr_row_q;
    logic [PE_W-1:0]    ptr_pe_q;
    logic [SCORE_W-1:0] score_q;
    logic [ID_W-1:0]    id_q;
    logic [CNT_W-1:0]   num_ids_q;
    logic               overflow_q;
    logic               done_q;
    logic               wr_en_q;
    logic [ROW_W-1:0]   wr_row_q;
    logic [PE_W-1:0]    wr_pe_q;
`ifdef OFLOW_CR_THRESHOLD_EN
    logic               th_hit_q;
`endif

    logic [HIST_DEPTH-1:0] slot_vld_q;
    logic [ID_W-1:0]       slot_id_q    [HIST_DEPTH];
    logic [SCORE_W-1:0]    slot_score_q [HIST_DEPTH];
    logic [ROW_W-1:0]      slot_row_q   [HIST_DEPTH];
    logic [PE_W-1:0]       slot_pe_q    [HIST_DEPTH];
    logic [CNT_W-1:0]      slot_cnt_q   [HIST_DEPTH];

    logic             hit;
    logic [IDX_W-1:0] hit_idx;
    logic [IDX_W-1:0] free_idx;
    logic             full;
    logic             better;
    logic             last_entry;
    logic             th_trip;
    logic             stop;
    logic [CNT_W-1:0] cnt_d;
    logic [ROW_W-1:0] ptr_row_d;
    logic [PE_W-1:0]  ptr_pe_d;

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < HIST_DEPTH; i++) begin
            if (!hit && slot_vld_q[i] && (slot_id_q[i] == id_q)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    // Slots are allocated in order, so the next free slot is simply num_ids.
    assign free_idx   = IDX_W'(num_ids_q);
    assign full       = (num_ids_q == CNT_W'(HIST_DEPTH));
    assign cnt_d      = (slot_cnt_q[hit_idx] == CNT_SAT) ? CNT_SAT : slot_cnt_q[hit_idx] + CNT_W'(1);
    assign better     = (score_q < slot_score_q[hit_idx]);
    assign last_entry = (ptr_row_q == LAST_ROW) && (ptr_pe_q == LAST_PE);
    assign ptr_pe_d   = (ptr_pe_q == LAST_PE) ? '0 : ptr_pe_q + PE_W'(1);
    assign ptr_row_d  = (ptr_pe_q == LAST_PE) ? ptr_row_q + ROW_W'(1) : ptr_row_q;

`ifdef OFLOW_CR_THRESHOLD_EN
    assign th_trip = hit && (int'(cnt_d) >= MAX_CONFLICTS_TH);
    assign th_hit  = th_hit_q;
`else
    assign th_trip = 1'b0;
    assign th_hit  = 1'b0;
`endif

    assign stop = (id_q == '0) || (!hit && full) || th_trip || last_entry;

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            state_q    <= IDLE;
            ptr_row_q  <= '0;
            ptr_pe_q   <= '0;
            score_q    <= '0;
            id_q       <= '0;
            num_ids_q  <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_row_q   <= '0;
            wr_pe_q    <= '0;
            slot_vld_q <= '0;
`ifdef OFLOW_CR_THRESHOLD_EN
            th_hit_q   <= 1'b0;
`endif
            for (int i = 0; i < HIST_DEPTH; i++) begin
                slot_id_q[i]    <= '0;
                slot_score_q[i] <= '0;
                slot_row_q[i]   <= '0;
                slot_pe_q[i]    <= '0;
                slot_cnt_q[i]   <= '0;
            end
        end else begin
            done_q  <= 1'b0;
            wr_en_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        state_q    <= READ;
                        ptr_row_q  <= '0;
                        ptr_pe_q   <= '0;
                        num_ids_q  <= '0;
                        overflow_q <= 1'b0;
                        slot_vld_q <= '0;
`ifdef OFLOW_CR_THRESHOLD_EN
                        th_hit_q   <= 1'b0;
`endif
                    end
                end
                READ: begin
                    if (abort) begin
                        state_q <= IDLE;
                    end else begin
                        id_q    <= rd_id;
                        score_q <= rd_score;
                        state_q <= RESOLVE;
                    end
                end
                RESOLVE: begin
                    if (abort) begin
                        state_q <= IDLE;
                    end else begin
                        if (id_q != '0) begin
                            if (hit) begin
                                wr_en_q             <= 1'b1;
                                slot_cnt_q[hit_idx] <= cnt_d;
                                if (better) begin
                                    wr_row_q              <= slot_row_q[hit_idx];
                                    wr_pe_q               <= slot_pe_q[hit_idx];
                                    slot_score_q[hit_idx] <= score_q;
                                    slot_row_q[hit_idx]   <= ptr_row_q;
                                    slot_pe_q[hit_idx]    <= ptr_pe_q;
                                end else begin
                                    wr_row_q <= ptr_row_q;
                                    wr_pe_q  <= ptr_pe_q;
                                end
`ifdef OFLOW_CR_THRESHOLD_EN
                                if (th_trip) th_hit_q <= 1'b1;
`endif
                            end else if (full) begin
                                overflow_q <= 1'b1;
                            end else begin
                                slot_vld_q[free_idx]   <= 1'b1;
                                slot_id_q[free_idx]    <= id_q;
                                slot_score_q[free_idx] <= score_q;
                                slot_row_q[free_idx]   <= ptr_row_q;
                                slot_pe_q[free_idx]    <= ptr_pe_q;
                                slot_cnt_q[free_idx]   <= CNT_W'(1);
                                num_ids_q              <= num_ids_q + CNT_W'(1);
                            end
                        end
                        if (stop) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            ptr_row_q <= ptr_row_d;
                            ptr_pe_q  <= ptr_pe_d;
                            state_q   <= READ;
                        end
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Abort suppresses the pending write and the done pulse in the cycle it is seen.
    assign busy     = (state_q != IDLE);
    assign done     = done_q && !abort;
    assign wr_en    = wr_en_q && !abort;
    assign wr_data  = wr_en;
    assign wr_row   = wr_row_q;
    assign wr_pe    = wr_pe_q;
    assign rd_row   = ptr_row_q;
    assign rd_pe    = ptr_pe_q;
    assign num_ids  = num_ids_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_oflow_conflict_resolve_gen2.sv
// Bench for oflow_conflict_resolve_gen2: default 4x4 instance and a 5x4 instance for overflow.
module tb_oflow_conflict_resolve_gen2;

    logic clk = 1'b0;
    logic reset_N = 1'b0;
    always #5 clk = ~clk;

    logic start_a = 1'b0, abort_a = 1'b0, start_b = 1'b0, abort_b = 1'b0;

    logic        busy_a, done_a, th_hit_a, overflow_a, wr_en_a, wr_data_a;
    logic [4:0]  num_ids_a;
    logic [1:0]  rd_row_a, rd_pe_a, wr_row_a, wr_pe_a;
    logic [15:0] rd_score_a;
    logic [11:0] rd_id_a;

    logic        busy_b, done_b, th_hit_b, overflow_b, wr_en_b, wr_data_b;
    logic [4:0]  num_ids_b;
    logic [2:0]  rd_row_b, wr_row_b;
    logic [1:0]  rd_pe_b, wr_pe_b;
    logic [15:0] rd_score_b;
    logic [11:0] rd_id_b;

    logic [11:0] board_id [32];
    logic [15:0] board_sc [32];

    assign rd_id_a    = board_id[{1'b0, rd_row_a, rd_pe_a}];
    assign rd_score_a = board_sc[{1'b0, rd_row_a, rd_pe_a}];
    assign rd_id_b    = board_id[{rd_row_b, rd_pe_b}];
    assign rd_score_b = board_sc[{rd_row_b, rd_pe_b}];

    oflow_conflict_resolve_gen2 u_dut_a (
        .clk(clk), .reset_N(reset_N), .start(start_a), .abort(abort_a),
        .busy(busy_a), .done(done_a), .th_hit(th_hit_a), .overflow(overflow_a),
        .num_ids(num_ids_a), .rd_row(rd_row_a), .rd_pe(rd_pe_a),
        .rd_score(rd_score_a), .rd_id(rd_id_a), .wr_en(wr_en_a),
        .wr_row(wr_row_a), .wr_pe(wr_pe_a), .wr_data(wr_data_a)
    );

    oflow_conflict_resolve_gen2 #(.NUM_ROWS(5)) u_dut_b (
        .clk(clk), .reset_N(reset_N), .start(start_b), .abort(abort_b),
        .busy(busy_b), .done(done_b), .th_hit(th_hit_b), .overflow(overflow_b),
        .num_ids(num_ids_b), .rd_row(rd_row_b), .rd_pe(rd_pe_b),
        .rd_score(rd_score_b), .rd_id(rd_id_b), .wr_en(wr_en_b),
        .wr_row(wr_row_b), .wr_pe(wr_pe_b), .wr_data(wr_data_b)
    );

    int sel = 0;
    logic o_busy, o_done, o_wr_en, o_wr_data, o_th, o_ovf;
    int o_num, o_wrow, o_wpe;

    always_comb begin
        if (sel == 0) begin
            o_busy = busy_a; o_done = done_a; o_wr_en = wr_en_a; o_wr_data = wr_data_a;
            o_th = th_hit_a; o_ovf = overflow_a; o_num = int'(num_ids_a);
            o_wrow = int'(wr_row_a); o_wpe = int'(wr_pe_a);
        end else begin
            o_busy = busy_b; o_done = done_b; o_wr_en = wr_en_b; o_wr_data = wr_data_b;
            o_th = th_hit_b; o_ovf = overflow_b; o_num = int'(num_ids_b);
            o_wrow = int'(wr_row_b); o_wpe = int'(wr_pe_b);
        end
    end

    int n_checks = 0;
    int n_pass = 0;

    int exp_wcyc[$];
    int exp_wpos[$];
    int exp_done;
    int exp_num;
    bit exp_ovf;
    bit exp_th;

    // Reference: per-ID histogram over the board in scan order; entry k resolves in cycle 2k+2.
    task automatic model(input int n, input int abort_cyc);
        int cnt[int];
        int mn[int];
        int pos[int];
        int stop_k;
        bit aborted;
        exp_wcyc.delete();
        exp_wpos.delete();
        exp_ovf = 1'b0;
        exp_th  = 1'b0;
        stop_k  = n - 1;
        aborted = 1'b0;
        for (int k = 0; k < n; k++) begin
            int id;
            int sc;
            if (abort_cyc > 0 && 2 * k + 2 >= abort_cyc) begin
                aborted = 1'b1;
                break;
            end
            id = int'(board_id[k]);
            sc = int'(board_sc[k]);
            if (id == 0) begin
                stop_k = k;
                break;
            end
            if (!cnt.exists(id)) begin
                if (cnt.num() == 16) begin
                    exp_ovf = 1'b1;
                    stop_k = k;
                    break;
                end
                cnt[id] = 1;
                mn[id]  = sc;
                pos[id] = k;
            end else begin
                int loser;
                cnt[id] = (cnt[id] >= 31) ? 31 : cnt[id] + 1;
                if (sc < mn[id]) begin
                    loser   = pos[id];
                    mn[id]  = sc;
                    pos[id] = k;
                end else begin
                    loser = k;
                end
                if (abort_cyc == 0 || 2 * k + 3 < abort_cyc) begin
                    exp_wcyc.push_back(2 * k + 3);
                    exp_wpos.push_back(loser);
                end
`ifdef OFLOW_CR_THRESHOLD_EN
                if (cnt[id] >= 10) begin
                    exp_th = 1'b1;
                    stop_k = k;
                    break;
                end
`endif
            end
        end
        exp_num  = cnt.num();
        exp_done = aborted ? -1 : 2 * stop_k + 3;
    endtask

    task automatic drive(input int s, input logic st, input logic ab);
        if (s == 0) begin
            start_a = st; abort_a = ab;
        end else begin
            start_b = st; abort_b = ab;
        end
    endtask

    task automatic run_scan(input int s, input int n, input int abort_cyc,
                            input int restart_cyc, input string name);
        int cyc;
        int done_at;
        int done_cnt;
        int limit;
        int got_cyc[$];
        int got_pos[$];
        sel = s;
        model(n, abort_cyc);
        done_at = -1;
        done_cnt = 0;
        cyc = 0;
        limit = (abort_cyc > 0) ? abort_cyc + 2 : 2 * n + 8;
        @(posedge clk); #1;
        drive(s, 1'b1, 1'b0);
        while (cyc < limit) begin
            @(posedge clk); #1;
            cyc++;
            drive(s, (cyc == restart_cyc), (cyc == abort_cyc));
            @(negedge clk);
            if (o_wr_en) begin
                got_cyc.push_back(cyc);
                got_pos.push_back(o_wrow * 4 + o_wpe);
                n_checks++;
                if (o_wr_data !== 1'b1) $display("FAIL %s wr_data cycle %0d: got %b expected 1", name, cyc, o_wr_data);
                else n_pass++;
            end
            if (o_done) begin
                done_cnt++;
                if (done_at < 0) done_at = cyc;
            end
            if (cyc == 1) begin
                n_checks++;
                if (o_busy !== 1'b1) $display("FAIL %s busy_after_start: got %b expected 1", name, o_busy);
                else n_pass++;
            end
            if ((abort_cyc > 0 && cyc == abort_cyc + 1) || (abort_cyc == 0 && done_at >= 0 && cyc == done_at + 1)) begin
                n_checks++;
                if (o_busy !== 1'b0) $display("FAIL %s busy_at_end cycle %0d: got %b expected 0", name, cyc, o_busy);
                else n_pass++;
                break;
            end
        end
        drive(s, 1'b0, 1'b0);

        n_checks++;
        if (abort_cyc == 0) begin
            if (done_at !== exp_done || done_cnt !== 1)
                $display("FAIL %s done: got cycle %0d (%0d pulses) expected cycle %0d (1 pulse)", name, done_at, done_cnt, exp_done);
            else n_pass++;
        end else begin
            if (done_cnt !== 0) $display("FAIL %s done_after_abort: got %0d pulses expected 0", name, done_cnt);
            else n_pass++;
        end
        n_checks++;
        if (got_cyc.size() !== exp_wcyc.size())
            $display("FAIL %s write_count: got %0d expected %0d", name, got_cyc.size(), exp_wcyc.size());
        else n_pass++;
        for (int i = 0; i < got_cyc.size() && i < exp_wcyc.size(); i++) begin
            n_checks++;
            if (got_cyc[i] !== exp_wcyc[i] || got_pos[i] !== exp_wpos[i])
                $display("FAIL %s write[%0d]: got cycle %0d pos (%0d,%0d) expected cycle %0d pos (%0d,%0d)",
                         name, i, got_cyc[i], got_pos[i] / 4, got_pos[i] % 4,
                         exp_wcyc[i], exp_wpos[i] / 4, exp_wpos[i] % 4);
            else n_pass++;
        end
        n_checks++;
        if (o_num !== exp_num) $display("FAIL %s num_ids: got %0d expected %0d", name, o_num, exp_num);
        else n_pass++;
        n_checks++;
        if (o_ovf !== exp_ovf) $display("FAIL %s overflow: got %b expected %b", name, o_ovf, exp_ovf);
        else n_pass++;
        n_checks++;
        if (o_th !== exp_th) $display("FAIL %s th_hit: got %b expected %b", name, o_th, exp_th);
        else n_pass++;
    endtask

    task automatic clear_board();
        for (int i = 0; i < 32; i++) begin
            board_id[i] = '0;
            board_sc[i] = '0;
        end
    endtask

    task automatic test_reset();
        logic [31:0] got;
        clear_board();
        reset_N = 1'b0;
        #12;
        got = {busy_a, done_a, th_hit_a, overflow_a, wr_en_a, wr_data_a, num_ids_a,
               rd_row_a, rd_pe_a, wr_row_a, wr_pe_a, 11'd0};
        n_checks++;
        if (got !== 32'd0) $display("FAIL reset_a outputs: got %h expected 0", got);
        else n_pass++;
        got = {busy_b, done_b, th_hit_b, overflow_b, wr_en_b, wr_data_b, num_ids_b,
               rd_row_b, rd_pe_b, wr_row_b, wr_pe_b, 9'd0};
        n_checks++;
        if (got !== 32'd0) $display("FAIL reset_b outputs: got %h expected 0", got);
        else n_pass++;
        @(negedge clk);
        reset_N = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy_a !== 1'b0 || busy_b !== 1'b0) $display("FAIL reset_idle busy: got %b%b expected 00", busy_a, busy_b);
        else n_pass++;
    endtask

    task automatic test_unique();
        clear_board();
        for (int k = 0; k < 16; k++) begin
            board_id[k] = 12'(k + 1);
            board_sc[k] = 16'($urandom_range(0, 65535));
        end
        run_scan(0, 16, 0, 0, "unique");
    endtask

    task automatic test_single_conflict();
        clear_board();
        for (int k = 0; k < 16; k++) begin
            board_id[k] = 12'(k + 20);
            board_sc[k] = 16'($urandom_range(0, 1000));
        end
        board_id[0] = 12'd5; board_sc[0] = 16'd100;
        board_id[6] = 12'd5; board_sc[6] = 16'd40;
        run_scan(0, 16, 0, 0, "single_conflict");
    endtask

    task automatic test_tie();
        clear_board();
        for (int k = 0; k < 16; k++) begin
            board_id[k] = 12'(k + 20);
            board_sc[k] = 16'($urandom_range(0, 1000));
        end
        board_id[1]  = 12'd7; board_sc[1]  = 16'd50;
        board_id[11] = 12'd7; board_sc[11] = 16'd50;
        run_scan(0, 16, 0, 0, "tie");
    endtask

    task automatic test_overflow();
        clear_board();
        for (int k = 0; k < 20; k++) begin
            board_id[k] = 12'(k + 1);
            board_sc[k] = 16'($urandom_range(0, 65535));
        end
        run_scan(1, 20, 0, 0, "overflow");
    endtask

    task automatic test_threshold();
        clear_board();
        for (int k = 0; k < 16; k++) begin
            board_id[k] = (k < 10) ? 12'd9 : 12'(100 + k);
            board_sc[k] = 16'($urandom_range(0, 300));
        end
        run_scan(0, 16, 0, 0, "threshold");
    endtask

    task automatic test_id_zero();
        clear_board();
        for (int k = 0; k < 16; k++) begin
            board_id[k] = 12'($urandom_range(1, 4));
            board_sc[k] = 16'($urandom_range(0, 7));
        end
        board_id[7] = 12'd0;
        run_scan(0, 16, 0, 0, "id_zero");
    endtask

    task automatic test_abort();
        clear_board();
        for (int k = 0; k < 16; k++) begin
            board_id[k] = 12'($urandom_range(1, 3));
            board_sc[k] = 16'($urandom_range(0, 7));
        end
        run_scan(0, 16, 6, 0, "abort");
        run_scan(0, 16, 0, 0, "rescan_after_abort");
    endtask

    task automatic test_start_while_busy();
        clear_board();
        for (int k = 0; k < 16; k++) begin
            board_id[k] = 12'($urandom_range(1, 6));
            board_sc[k] = 16'($urandom_range(0, 15));
        end
        run_scan(0, 16, 0, 4, "start_while_busy");
    endtask

    task automatic test_start_abort_idle();
        sel = 0;
        @(posedge clk); #1;
        start_a = 1'b1;
        abort_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        abort_a = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy_a !== 1'b0) $display("FAIL start_abort_idle busy: got %b expected 0", busy_a);
        else n_pass++;
        n_checks++;
        if (int'(num_ids_a) !== exp_num) $display("FAIL start_abort_idle num_ids: got %0d expected %0d", num_ids_a, exp_num);
        else n_pass++;
    endtask

    task automatic test_random();
        int ranges[4] = '{2, 3, 8, 24};
        for (int it = 0; it < 8; it++) begin
            int s;
            int n;
            int r;
            s = it % 2;
            n = (s == 0) ? 16 : 20;
            r = ranges[$urandom_range(0, 3)];
            clear_board();
            for (int k = 0; k < n; k++) begin
                board_id[k] = ($urandom_range(0, 19) == 0) ? 12'd0 : 12'($urandom_range(1, r));
                board_sc[k] = 16'($urandom_range(0, 7));
            end
            run_scan(s, n, 0, 0, $sformatf("random%0d", it));
        end
    endtask

    initial begin
        test_reset();
        test_unique();
        test_single_conflict();
        test_tie();
        test_overflow();
        test_threshold();
        test_id_zero();
        test_abort();
        test_start_while_busy();
        test_start_abort_idle();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
